led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_pkg.sv | 13 +
 rtl/led_sequencer_tick.sv | 29 ++
 rtl/led_sequencer.sv | 127 ++++++++++++
 tb/tb_led_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: configuration modes and FSM states.
package led_sequencer_pkg;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STATIC = 2'd1;
   localparam logic [1:0] MODE_SHIFT  = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/led_sequencer_tick.sv
// Step counter for the LED sequencer: counts 0..P-1 (P = max(period,1)) and
// flags the wrap cycle. Held at 0 while restart is high.
module led_sequencer_tick #(
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    clk_ext,
   input  logic                    rst_ext,
   input  logic                    restart,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    wrap
);

   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, last;

   // A period of 0 behaves as 1, so the terminal count never underflows.
   assign last = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
   assign wrap = !restart && (cnt_q == last);

   always_comb begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
      if (restart || wrap) cnt_d = '0;
   end

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer (OFF/STATIC/SHIFT/BLINK) with an IDLE/LOAD/RUN FSM.
// Define LED_SEQUENCER_PWM_EN to add the cfg_duty port and 16-step PWM dimming.
module led_sequencer
   import led_sequencer_pkg::*;
#(
   parameter int NUM_LEDS     = 4,
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    clk_ext,
   input  logic                    rst_ext,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [1:0]              cfg_mode,
   input  logic [NUM_LEDS-1:0]     cfg_pattern,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
`ifdef LED_SEQUENCER_PWM_EN
   input  logic [3:0]              cfg_duty,
`endif
   output logic [NUM_LEDS-1:0]     led,
   output logic                    step_strobe,
   output logic                    busy
);

   logic [1:0]              state_q, state_d, mode_q, mode_d;
   logic [NUM_LEDS-1:0]     cfg_pat_q, cfg_pat_d, pat_q, pat_d, led_q, led_d, rot, mask;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    strobe_q, hs, wrap;

   assign hs          = cfg_valid && cfg_ready;
   assign cfg_ready   = (state_q != ST_LOAD);
   assign busy        = (state_q != ST_IDLE);
   assign led         = led_q;
   assign step_strobe = strobe_q;

   if (NUM_LEDS == 1) begin : g_rot1
      assign rot = pat_q;
   end else begin : g_rotn
      assign rot = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
   end

   led_sequencer_tick #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_tick (
      .clk_ext (clk_ext),
      .rst_ext (rst_ext),
      .restart (state_q != ST_RUN),
      .period  (period_q),
      .wrap    (wrap)
   );

`ifdef LED_SEQUENCER_PWM_EN
   logic [3:0] duty_q, pwm_q;

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         duty_q <= '0;
         pwm_q  <= '0;
      end else begin
         pwm_q <= pwm_q + 4'd1;
         if (hs) duty_q <= cfg_duty;
      end
   end

   assign mask = {NUM_LEDS{pwm_q < duty_q}};
`else
   assign mask = '1;
`endif

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cfg_pat_d = cfg_pat_q;
      period_d  = period_q;
      pat_d     = pat_q;
      case (state_q)
         ST_IDLE: ;
         ST_LOAD: begin
            if (mode_q == MODE_OFF) begin
               state_d = ST_IDLE;
               pat_d   = '0;
            end else begin
               state_d = ST_RUN;
               pat_d   = cfg_pat_q;
            end
         end
         ST_RUN: begin
            // A new configuration wins over a coincident step update.
            if (wrap && !hs) begin
               case (mode_q)
                  MODE_SHIFT: pat_d = rot;
                  MODE_BLINK: pat_d = ~pat_q;
                  default:    pat_d = pat_q;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (hs) begin
         state_d   = ST_LOAD;
         mode_d    = cfg_mode;
         cfg_pat_d = cfg_pattern;
         period_d  = cfg_period;
      end
   end

   // The LED register lags the pattern register by one edge, including in LOAD.
   assign led_d = (state_q == ST_IDLE) ? '0 : (pat_q & mask);

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_OFF;
         cfg_pat_q <= '0;
         period_q  <= '0;
         pat_q     <= '0;
         led_q     <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         cfg_pat_q <= cfg_pat_d;
         period_q  <= period_d;
         pat_q     <= pat_d;
         led_q     <= led_d;
         strobe_q  <= wrap;
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed scoreboard bench for led_sequencer (NUM_LEDS=4, PERIOD_WIDTH=24).
module tb_led_sequencer;

   localparam int N  = 4;
   localparam int PW = 24;

   localparam logic [1:0] M_OFF = 2'd0, M_STATIC = 2'd1, M_SHIFT = 2'd2, M_BLINK = 2'd3;

   logic          clk_ext = 1'b0;
   logic          rst_ext = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [1:0]    cfg_mode = '0;
   logic [N-1:0]  cfg_pattern = '0;
   logic [PW-1:0] cfg_period = '0;
`ifdef LED_SEQUENCER_PWM_EN
   logic [3:0]    cfg_duty = '0;
`endif
   logic [N-1:0]  led;
   logic          step_strobe;
   logic          busy;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk_ext = ~clk_ext;

   led_sequencer #(.NUM_LEDS(N), .PERIOD_WIDTH(PW)) dut (
      .clk_ext     (clk_ext),
      .rst_ext     (rst_ext),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_mode    (cfg_mode),
      .cfg_pattern (cfg_pattern),
      .cfg_period  (cfg_period),
`ifdef LED_SEQUENCER_PWM_EN
      .cfg_duty    (cfg_duty),
`endif
      .led         (led),
      .step_strobe (step_strobe),
      .busy        (busy)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_ext);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_underflow: observed %0h expected none", obs);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.exp);
      end
   endtask

   // Drive a one-cycle handshake; returns one step after the handshake edge.
   task automatic hs(input logic [1:0] m, input logic [N-1:0] p, input logic [PW-1:0] per);
      cfg_valid   = 1'b1;
      cfg_mode    = m;
      cfg_pattern = p;
      cfg_period  = per;
      tick(1);
      cfg_valid   = 1'b0;
   endtask

   function automatic logic [N-1:0] rotl(input logic [N-1:0] p, input int n);
      logic [N-1:0] r;
      r = p;
      for (int i = 0; i < n; i++) r = {r[N-2:0], r[N-1]};
      return r;
   endfunction

   initial begin
      // Reset state
      tick(2);
      check("rst_led",    32'(led), 32'h0);
      check("rst_strobe", 32'(step_strobe), 32'h0);
      check("rst_busy",   32'(busy), 32'h0);
      check("rst_ready",  32'(cfg_ready), 32'h1);
      rst_ext = 1'b0;
      tick(1);
      check("idle_busy", 32'(busy), 32'h0);

`ifndef LED_SEQUENCER_PWM_EN
      // SHIFT 0001, period 3
      hs(M_SHIFT, 4'b0001, 24'd3);
      for (int k = 2; k <= 16; k++) begin
         push($sformatf("shift_led_%0d", k), 32'(rotl(4'b0001, (k - 2) / 3)));
         push($sformatf("shift_stb_%0d", k), 32'((k >= 4 && (k - 4) % 3 == 0) ? 1 : 0));
      end
      check("load_ready", 32'(cfg_ready), 32'h0);
      check("load_busy",  32'(busy), 32'h1);
      tick(1);
      check("run_ready", 32'(cfg_ready), 32'h1);
      check("run_led0",  32'(led), 32'h0);
      for (int k = 2; k <= 16; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end

      // Asynchronous reset in the middle of a cycle
      #2 rst_ext = 1'b1;
      #1;
      check("arst_led",    32'(led), 32'h0);
      check("arst_strobe", 32'(step_strobe), 32'h0);
      check("arst_busy",   32'(busy), 32'h0);
      check("arst_ready",  32'(cfg_ready), 32'h1);
      tick(2);
      rst_ext = 1'b0;
      tick(3);
      check("post_rst_busy", 32'(busy), 32'h0);
      check("post_rst_led",  32'(led), 32'h0);

      // BLINK 1010, period 0 (treated as 1)
      hs(M_BLINK, 4'b1010, 24'd0);
      for (int k = 2; k <= 9; k++) begin
         push($sformatf("blink_led_%0d", k), 32'((k % 2 == 0) ? 4'b1010 : 4'b0101));
         push($sformatf("blink_stb_%0d", k), 32'h1);
      end
      tick(1);
      check("blink_stb_first", 32'(step_strobe), 32'h0);
      for (int k = 2; k <= 9; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end

      // Handshake from RUN on a wrap edge: strobe kept, inversion discarded
      hs(M_SHIFT, 4'b0011, 24'd5);
      check("rehs_stb",   32'(step_strobe), 32'h1);
      check("rehs_ready", 32'(cfg_ready), 32'h0);
      tick(1);
      check("rehs_discard_led", 32'(led), 32'(4'b1010));
      check("rehs_stb_load",    32'(step_strobe), 32'h0);
      for (int k = 2; k <= 10; k++) begin
         push($sformatf("p5_led_%0d", k), 32'((k <= 6) ? 4'b0011 : 4'b0110));
         push($sformatf("p5_stb_%0d", k), 32'((k == 6) ? 1 : 0));
      end
      for (int k = 2; k <= 10; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end

      // STATIC 1111 handshake exactly on the SHIFT wrap edge
      hs(M_STATIC, 4'b1111, 24'd2);
      check("wraphs_stb", 32'(step_strobe), 32'h1);
      check("wraphs_led", 32'(led), 32'(4'b0110));
      tick(1);
      check("wraphs_norot_led", 32'(led), 32'(4'b0110));
      check("wraphs_stb_once",  32'(step_strobe), 32'h0);
      for (int k = 13; k <= 17; k++) begin
         push($sformatf("static_led_%0d", k), 32'(4'b1111));
         push($sformatf("static_stb_%0d", k), 32'((k == 14 || k == 16) ? 1 : 0));
      end
      for (int k = 13; k <= 17; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end

      // cfg_valid held through LOAD with different fields: must be ignored
      cfg_valid   = 1'b1;
      cfg_mode    = M_SHIFT;
      cfg_pattern = 4'b1000;
      cfg_period  = 24'd4;
      tick(1);
      check("hold_ready_load", 32'(cfg_ready), 32'h0);
      cfg_mode    = M_BLINK;
      cfg_pattern = 4'b0110;
      cfg_period  = 24'd1;
      tick(1);
      check("hold_ready_run", 32'(cfg_ready), 32'h1);
      cfg_valid = 1'b0;
      for (int k = 2; k <= 7; k++) begin
         push($sformatf("hold_led_%0d", k), 32'((k <= 5) ? 4'b1000 : 4'b0001));
         push($sformatf("hold_stb_%0d", k), 32'((k == 5) ? 1 : 0));
      end
      for (int k = 2; k <= 7; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end

      // OFF returns to IDLE with dark LEDs
      hs(M_OFF, 4'b1111, 24'd0);
      check("off_busy_load", 32'(busy), 32'h1);
      check("off_ready",     32'(cfg_ready), 32'h0);
      tick(1);
      check("off_busy_idle", 32'(busy), 32'h0);
      tick(1);
      check("off_led", 32'(led), 32'h0);
      tick(3);
      check("off_led_hold", 32'(led), 32'h0);
      check("off_stb_hold", 32'(step_strobe), 32'h0);

      // SHIFT with all-ones stays constant
      hs(M_SHIFT, 4'b1111, 24'd1);
      tick(1);
      for (int k = 2; k <= 6; k++) begin
         push($sformatf("ones_led_%0d", k), 32'(4'b1111));
         push($sformatf("ones_stb_%0d", k), 32'h1);
      end
      for (int k = 2; k <= 6; k++) begin
         tick(1);
         pop_chk(32'(led));
         pop_chk(32'(step_strobe));
      end
`else
      begin
         int on_cnt;
         cfg_duty = 4'd4;
         hs(M_STATIC, 4'b1111, 24'd1);
         tick(3);
         on_cnt = 0;
         for (int i = 0; i < 16; i++) begin
            check($sformatf("pwm4_uniform_%0d", i), 32'(led), 32'(led[0] ? 4'b1111 : 4'b0000));
            if (led[0]) on_cnt++;
            tick(1);
         end
         check("pwm4_on_cycles", 32'(on_cnt), 32'd4);
         cfg_duty = 4'd0;
         hs(M_STATIC, 4'b1111, 24'd1);
         tick(3);
         on_cnt = 0;
         for (int i = 0; i < 16; i++) begin
            if (led != '0) on_cnt++;
            tick(1);
         end
         check("pwm0_on_cycles", 32'(on_cnt), 32'd0);
      end
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
